// File: rtl/write_req_pkg.sv
// Shared types and helpers for the write-request FIFO.
// Default request layout plus pointer sizing.
package write_req_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 8;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] address;
    logic [DATA_WIDTH_DEF-1:0] data;
  } write_req_t;

  // Index bits plus one wrap bit
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/write_req_fifo_mem.sv
// Write-request storage: one write port, async read port.
// Contents are deliberately left unreset.
module write_req_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/write_req_fifo.sv
// First-word fall-through FIFO for write requests.
// Wrap-bit pointers; occupancy is their difference.
module write_req_fifo
  import write_req_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        flush,
  input  logic [ADDR_WIDTH-1:0]       in_address,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ADDR_WIDTH-1:0]       out_address,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ptr_width(DEPTH)-1:0] count,
  output logic                        almost_full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] AF  = PW'(AF_LEVEL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("AF_LEVEL must be in 1..DEPTH");
  end

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] cnt;
  logic          full, empty;
  logic          push, pop;
  logic [EW-1:0] rdata;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[IW-1:0] == rd_q[IW-1:0]) &&
                 (wr_q[PW-1] != rd_q[PW-1]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Modulo-2*DEPTH difference gives 0..DEPTH
  assign cnt         = wr_q - rd_q;
  assign count       = cnt;
  assign almost_full = (cnt >= AF);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + ONE;
      if (pop)  rd_d = rd_q + ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  write_req_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push && !flush),
    .waddr_i (wr_q[IW-1:0]),
    .wdata_i ({in_address, in_data}),
    .raddr_i (rd_q[IW-1:0]),
    .rdata_o (rdata)
  );

  assign {out_address, out_data} = rdata;

endmodule
